prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 32 +++
 rtl/loader_checksum.sv | 34 +++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the byte-stream program loader.
//   - loaderState_t : FSM state encoding (SYNC, LEN, ADDR, DATA, CHECK)
//   - frameField_t  : frame field order on the wire
//   - DEFAULT_SYNC_BYTE : default frame start marker
//   - lenToCount()  : maps the LEN field to a 9-bit payload byte count
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StSync,
        StLen,
        StAddr,
        StData,
        StCheck
    } loaderState_t;

    // Frame layout: SYNC, LEN, ADDR, LEN data bytes, CHK.
    typedef enum logic [2:0] {
        FieldSync,
        FieldLen,
        FieldAddr,
        FieldData,
        FieldChk
    } frameField_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h5A;

    // A LEN of zero encodes a full 256-byte payload.
    function automatic logic [8:0] lenToCount(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// loader_checksum: 8-bit running modulo-256 sum for the program loader.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : zero the running sum (takes priority over add)
//   add          : add data to the running sum this cycle
//   data         : byte to add / test against
//   sum          : current running sum
//   zeroWithData : (sum + data) mod 256 == 0, used to test the checksum byte
module loader_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] sum,
    output logic       zeroWithData
);

    logic [7:0] total;

    assign total        = sum + data;
    assign zeroWithData = (total == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 8'd0;
        end else if (clear) begin
            sum <= 8'd0;
        end else if (add) begin
            sum <= total;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader writing framed payloads into the
// 8-bit-addressed program memory and holding the CPU while loading.
// Frame: SYNC_BYTE, LEN, ADDR, LEN data bytes, CHK (LEN+ADDR+data+CHK == 0 mod 256).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   rxData/rxValid  : incoming byte stream; rxReady accepts (transfer = rxValid & rxReady)
//   memAddr         : write address (wraps FF -> 00 within a frame)
//   memDataWrite    : write data
//   memWriteStrobe  : write request, held until memReady
//   memReady        : memory accepted the write this cycle
//   cpuHold         : processor held while loading or after a bad frame
//   loadDone        : one-cycle pulse on a good checksum
//   loadError       : sticky error (bad checksum or timeout), cleared by next sync byte
// Build option: define LOADER_TIMEOUT_EN to abort a stalled frame after TIMEOUT_CYCLES
// idle cycles; without it the loader waits indefinitely.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter bit          HOLD_AT_RESET  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    output logic       rxReady,
    output logic [7:0] memAddr,
    output logic [7:0] memDataWrite,
    output logic       memWriteStrobe,
    input  logic       memReady,
    output logic       cpuHold,
    output logic       loadDone,
    output logic       loadError
);

    loaderState_t state;
    logic [8:0]   count;
    logic         accept;
    logic         csClear;
    logic         csAdd;
    logic [7:0]   csSum;
    logic         csZero;
    logic         timeoutFire;

    assign accept  = rxValid & rxReady;
    assign csClear = accept && (state == StSync) && (rxData == SYNC_BYTE);
    assign csAdd   = accept && ((state == StLen) || (state == StAddr) || (state == StData));

    loader_checksum uChecksum (
        .clk          (clk),
        .reset        (reset),
        .clear        (csClear),
        .add          (csAdd),
        .data         (rxData),
        .sum          (csSum),
        .zeroWithData (csZero)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] idleCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idleCount <= 32'd0;
        end else if (accept || (state == StSync)) begin
            idleCount <= 32'd0;
        end else if (idleCount < 32'(TIMEOUT_CYCLES)) begin
            idleCount <= idleCount + 32'd1;
        end
    end

    // An outstanding write must finish before the frame is abandoned.
    assign timeoutFire = (state != StSync) && !accept && !memWriteStrobe &&
                         (idleCount >= 32'(TIMEOUT_CYCLES) - 32'd1);
`else
    assign timeoutFire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= StSync;
            count          <= 9'd0;
            rxReady        <= 1'b1;
            memAddr        <= 8'd0;
            memDataWrite   <= 8'd0;
            memWriteStrobe <= 1'b0;
            cpuHold        <= HOLD_AT_RESET;
            loadDone       <= 1'b0;
            loadError      <= 1'b0;
        end else begin
            loadDone <= 1'b0;

            // Reopen the byte stream one cycle after a write handshake completes.
            if (!rxReady && !memWriteStrobe) begin
                rxReady <= 1'b1;
            end

            case (state)
                StSync: begin
                    if (accept && (rxData == SYNC_BYTE)) begin
                        loadError <= 1'b0;
                        cpuHold   <= 1'b1;
                        state     <= StLen;
                    end
                end
                StLen: begin
                    if (accept) begin
                        count <= lenToCount(rxData);
                        state <= StAddr;
                    end
                end
                StAddr: begin
                    if (accept) begin
                        memAddr <= rxData;
                        state   <= StData;
                    end
                end
                StData: begin
                    if (accept) begin
                        memDataWrite   <= rxData;
                        memWriteStrobe <= 1'b1;
                        rxReady        <= 1'b0;
                    end else if (memWriteStrobe && memReady) begin
                        memWriteStrobe <= 1'b0;
                        memAddr        <= memAddr + 8'd1;
                        count          <= count - 9'd1;
                        if (count == 9'd1) begin
                            state <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        if (csZero) begin
                            loadDone <= 1'b1;
                            cpuHold  <= 1'b0;
                        end else begin
                            loadError <= 1'b1;
                        end
                        state <= StSync;
                    end
                end
                default: state <= StSync;
            endcase

            if (timeoutFire) begin
                state     <= StSync;
                loadError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxData = 8'd0;
    logic       rxValid = 1'b0;
    logic       rxReady;
    logic [7:0] memAddr;
    logic [7:0] memDataWrite;
    logic       memWriteStrobe;
    logic       memReady = 1'b1;
    logic       cpuHold;
    logic       loadDone;
    logic       loadError;

    int checks = 0;
    int errors = 0;

    logic [7:0] wrAddr[$];
    logic [7:0] wrData[$];
    logic [7:0] txq[$];
    int doneCnt = 0;
    int stabErr = 0;
    int rdyErr = 0;
    int readyMode = 0;   // 0: always ready, 1: stall 4 cycles per write, 2: never ready
    int stall = 0;

    logic       pStrobe = 1'b0;
    logic       pReady = 1'b0;
    logic [7:0] pAddr = 8'd0;
    logic [7:0] pData = 8'd0;

    prog_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rxData         (rxData),
        .rxValid        (rxValid),
        .rxReady        (rxReady),
        .memAddr        (memAddr),
        .memDataWrite   (memDataWrite),
        .memWriteStrobe (memWriteStrobe),
        .memReady       (memReady),
        .cpuHold        (cpuHold),
        .loadDone       (loadDone),
        .loadError      (loadError)
    );

    always #5 clk = ~clk;

    // Memory-side responder.
    always @(negedge clk) begin
        if (readyMode == 0) begin
            memReady = 1'b1;
        end else if (readyMode == 2) begin
            memReady = 1'b0;
        end else if (memWriteStrobe) begin
            if (stall >= 4) begin
                memReady = 1'b1;
            end else begin
                memReady = 1'b0;
                stall++;
            end
        end else begin
            stall = 0;
            memReady = 1'b0;
        end
    end

    // Write log plus protocol observations.
    always @(posedge clk) begin
        if (!reset) begin
            if (memWriteStrobe && memReady) begin
                wrAddr.push_back(memAddr);
                wrData.push_back(memDataWrite);
            end
            if (loadDone) doneCnt++;
            if (memWriteStrobe && rxReady) rdyErr++;
            if (pStrobe && !pReady &&
                (!memWriteStrobe || memAddr !== pAddr || memDataWrite !== pData)) stabErr++;
        end
        pStrobe = memWriteStrobe;
        pReady  = memReady;
        pAddr   = memAddr;
        pData   = memDataWrite;
    end

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_wait byte=%h rxReady=%b required 1", b, rxReady);
        end
        @(posedge clk);
        #1 rxValid = 1'b0;
    endtask

    task automatic sendQueue();
        foreach (txq[i]) sendByte(txq[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        doneCnt = 0;
        stabErr = 0;
        rdyErr  = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({memAddr, memDataWrite, memWriteStrobe, loadDone, loadError, cpuHold, rxReady}
            !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got addr=%h data=%h stb=%b done=%b err=%b hold=%b rdy=%b required 00 00 0 0 0 1 1",
                     memAddr, memDataWrite, memWriteStrobe, loadDone, loadError, cpuHold, rxReady);
        end
    endtask

    task automatic test_basic();
        logic [7:0] eA[3] = '{8'h10, 8'h11, 8'h12};
        logic [7:0] eD[3] = '{8'hAA, 8'hBB, 8'hCC};
        clearLog();
        txq = '{8'h5A, 8'h03, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hBC};
        sendQueue();
        checks++;
        if (wrAddr.size() != 3) begin
            errors++;
            $display("FAIL basic_count got %0d required 3", wrAddr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrAddr.size() <= i || wrAddr[i] !== eA[i] || wrData[i] !== eD[i]) begin
                errors++;
                $display("FAIL basic_write%0d got %h@%h required %h@%h",
                         i, wrData[i], wrAddr[i], eD[i], eA[i]);
            end
        end
        checks++;
        if (doneCnt != 1 || cpuHold !== 1'b0 || loadError !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got done=%0d hold=%b err=%b required 1 0 0",
                     doneCnt, cpuHold, loadError);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] eA[3] = '{8'hFE, 8'hFF, 8'h00};
        logic [7:0] eD[3] = '{8'h11, 8'h22, 8'h33};
        clearLog();
        txq = '{8'h5A, 8'h03, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h99};
        sendQueue();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrAddr.size() <= i || wrAddr[i] !== eA[i] || wrData[i] !== eD[i]) begin
                errors++;
                $display("FAIL wrap_write%0d got %h@%h required %h@%h",
                         i, wrData[i], wrAddr[i], eD[i], eA[i]);
            end
        end
        checks++;
        if (wrAddr.size() != 3 || doneCnt != 1) begin
            errors++;
            $display("FAIL wrap_status got writes=%0d done=%0d required 3 1",
                     wrAddr.size(), doneCnt);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] eA[3] = '{8'h10, 8'h11, 8'h12};
        logic [7:0] eD[3] = '{8'hAA, 8'hBB, 8'hCC};
        clearLog();
        readyMode = 1;
        txq = '{8'h5A, 8'h03, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hBC};
        sendQueue();
        readyMode = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrAddr.size() <= i || wrAddr[i] !== eA[i] || wrData[i] !== eD[i]) begin
                errors++;
                $display("FAIL bp_write%0d got %h@%h required %h@%h",
                         i, wrData[i], wrAddr[i], eD[i], eA[i]);
            end
        end
        checks++;
        if (stabErr != 0 || rdyErr != 0) begin
            errors++;
            $display("FAIL bp_hold got unstable=%0d readyDuringWrite=%0d required 0 0",
                     stabErr, rdyErr);
        end
        checks++;
        if (wrAddr.size() != 3 || doneCnt != 1 || cpuHold !== 1'b0) begin
            errors++;
            $display("FAIL bp_status got writes=%0d done=%0d hold=%b required 3 1 0",
                     wrAddr.size(), doneCnt, cpuHold);
        end
    endtask

    task automatic test_bad_checksum();
        clearLog();
        txq = '{8'h5A, 8'h03, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hBD};
        sendQueue();
        checks++;
        if (wrAddr.size() != 3 || loadError !== 1'b1 || cpuHold !== 1'b1 || doneCnt != 0) begin
            errors++;
            $display("FAIL bad_chk got writes=%0d err=%b hold=%b done=%0d required 3 1 1 0",
                     wrAddr.size(), loadError, cpuHold, doneCnt);
        end
        clearLog();
        txq = '{8'h5A, 8'h03, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hBC};
        sendQueue();
        checks++;
        if (loadError !== 1'b0 || doneCnt != 1 || cpuHold !== 1'b0) begin
            errors++;
            $display("FAIL bad_recover got err=%b done=%0d hold=%b required 0 1 0",
                     loadError, doneCnt, cpuHold);
        end
    endtask

    task automatic test_garbage();
        clearLog();
        txq = '{8'h00, 8'hFF, 8'h5A, 8'h01, 8'h20, 8'h7E, 8'h61};
        sendQueue();
        checks++;
        if (wrAddr.size() != 1 || wrAddr[0] !== 8'h20 || wrData[0] !== 8'h7E || doneCnt != 1)
        begin
            errors++;
            $display("FAIL garbage got writes=%0d first=%h@%h done=%0d required 1 7e@20 1",
                     wrAddr.size(), wrData[0], wrAddr[0], doneCnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        clearLog();
        txq = '{8'h5A, 8'h02, 8'h30};
        foreach (txq[i]) sendByte(txq[i]);
        readyMode = 2;
        sendByte(8'h44);
        repeat (2) @(negedge clk);
        checks++;
        if (memWriteStrobe !== 1'b1 || memAddr !== 8'h30 || cpuHold !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pending got stb=%b addr=%h hold=%b required 1 30 1",
                     memWriteStrobe, memAddr, cpuHold);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({memAddr, memDataWrite, memWriteStrobe, loadDone, loadError, cpuHold, rxReady}
            !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midframe_reset got addr=%h data=%h stb=%b done=%b err=%b hold=%b rdy=%b required 00 00 0 0 0 1 1",
                     memAddr, memDataWrite, memWriteStrobe, loadDone, loadError, cpuHold, rxReady);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        readyMode = 0;
        checks++;
        if (wrAddr.size() != 0) begin
            errors++;
            $display("FAIL midframe_nowrite got writes=%0d required 0", wrAddr.size());
        end
        // Loader must be back in SYNC: a fresh frame loads normally.
        test_garbage();
    endtask

    task automatic test_len_zero();
        int bad = 0;
        clearLog();
        txq = '{8'h5A, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) txq.push_back(8'(i));
        txq.push_back(8'h80);
        sendQueue();
        checks++;
        if (wrAddr.size() != 256) begin
            errors++;
            $display("FAIL len0_count got %0d required 256", wrAddr.size());
        end
        for (int i = 0; i < wrAddr.size(); i++) begin
            if (wrAddr[i] !== 8'(i) || wrData[i] !== 8'(i)) bad++;
        end
        checks++;
        if (bad != 0 || doneCnt != 1 || loadError !== 1'b0) begin
            errors++;
            $display("FAIL len0_content got badWrites=%0d done=%0d err=%b required 0 1 0",
                     bad, doneCnt, loadError);
        end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        clearLog();
        sendByte(8'h5A);
        sendByte(8'h05);
        repeat (990) @(negedge clk);
        checks++;
        if (loadError !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got err=%b required 0", loadError);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (loadError !== 1'b1 || cpuHold !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got err=%b hold=%b required 1 1", loadError, cpuHold);
        end
        test_garbage();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_bad_checksum();
        test_garbage();
        test_reset_mid_frame();
        test_len_zero();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
